apb_master_arbiter: RTL and testbench

Shares one APB master port among NREQ local requesters and sequences each APB transfer. The block arbitrates round-robin, latches the winning request, and drives the APB SETUP and ACCESS phases. It waits out PREADY wait states, bounded by an optional timeout. The result (read data and error) returns to the winning requester as a single-cycle response pulse. The block sits between the bridge-side request logic and the APB slave interface (PSEL/PENABLE/PADDR/...).

---
 rtl/apb_master_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB master port among NREQ requesters.
// Requests are arbitrated round-robin. The winning request is latched into the
// APB output registers, and the SETUP/ACCESS phases are sequenced from there.
// PREADY wait states are bounded by an optional timeout. The result returns to
// the winner as a one-cycle rsp_valid pulse.
//
// Ports:
//   PCLK, PRESETn                 clock, async active-low reset
//   req_valid/write/addr/wdata/   packed per-requester request fields
//   req_strb/prot                 (slice i belongs to requester i)
//   req_ready                     one-hot accept pulse
//   rsp_valid/rsp_rdata/rsp_err   one-hot completion pulse with read data and error
//   PSEL..PWDATA                  APB master outputs (all registered)
//   PRDATA, PREADY, PSLVERR       APB slave returns
module apb_master_arbiter #(
    parameter int unsigned PDATA_SIZE = 32,
    parameter int unsigned NREQ       = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0]              req_write,
    input  logic [NREQ*PDATA_SIZE-1:0]   req_addr,
    input  logic [NREQ*PDATA_SIZE-1:0]   req_wdata,
    input  logic [NREQ*PDATA_SIZE/8-1:0] req_strb,
    input  logic [NREQ*3-1:0]            req_prot,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [PDATA_SIZE-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [2:0]                   PPROT,
    output logic [PDATA_SIZE/8-1:0]      PSTRB,
    output logic [PDATA_SIZE-1:0]        PADDR,
    output logic [PDATA_SIZE-1:0]        PWDATA,
    input  logic [PDATA_SIZE-1:0]        PRDATA,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);

    localparam int unsigned SW = PDATA_SIZE / 8;
    localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [GW-1:0]         last_grant, last_grant_nxt;
    logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
    logic [GW-1:0]         cand;
    logic [GW-1:0]         winner;
    logic                  found;

    logic [NREQ-1:0]       req_ready_nxt, rsp_valid_nxt;
    logic [PDATA_SIZE-1:0] rsp_rdata_nxt;
    logic                  rsp_err_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt;
    logic [2:0]            pprot_nxt;
    logic [SW-1:0]         pstrb_nxt;
    logic [PDATA_SIZE-1:0] paddr_nxt, pwdata_nxt;

    // Round-robin search starting just after the last granted requester.
    always_comb begin : rr_search
        found  = 1'b0;
        winner = last_grant;
        cand   = last_grant;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = GW'((32'(last_grant) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin : fsm_comb
        state_nxt      = state;
        last_grant_nxt = last_grant;
        wait_cnt_nxt   = wait_cnt;
        req_ready_nxt  = '0;
        rsp_valid_nxt  = '0;
        rsp_rdata_nxt  = rsp_rdata;
        rsp_err_nxt    = rsp_err;
        psel_nxt       = PSEL;
        penable_nxt    = PENABLE;
        pwrite_nxt     = PWRITE;
        pprot_nxt      = PPROT;
        pstrb_nxt      = PSTRB;
        paddr_nxt      = PADDR;
        pwdata_nxt     = PWDATA;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt      = SETUP;
                    last_grant_nxt = winner;
                    wait_cnt_nxt   = '0;
                    req_ready_nxt  = NREQ'(1) << winner;
                    psel_nxt       = 1'b1;
                    penable_nxt    = 1'b0;
                    pwrite_nxt     = req_write[winner];
                    paddr_nxt      = req_addr[32'(winner) * PDATA_SIZE +: PDATA_SIZE];
                    pwdata_nxt     = req_wdata[32'(winner) * PDATA_SIZE +: PDATA_SIZE];
                    pprot_nxt      = req_prot[32'(winner) * 3 +: 3];
                    // Reads never drive strobes.
                    pstrb_nxt      = req_write[winner] ? req_strb[32'(winner) * SW +: SW] : '0;
                end
            end

            SETUP: begin
                state_nxt   = ACCESS;
                penable_nxt = 1'b1;
            end

            ACCESS: begin
                if (PREADY) begin
                    state_nxt     = IDLE;
                    rsp_valid_nxt = NREQ'(1) << last_grant;
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                    rsp_err_nxt   = PSLVERR;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                end else begin
                    if (wait_cnt != '1) begin
                        wait_cnt_nxt = wait_cnt + CW'(1);
                    end
                    // This low edge is the TIMEOUT-th consecutive one: abort.
                    if (TIMEOUT != 0 && (32'(wait_cnt) + 32'd1) == TIMEOUT) begin
                        state_nxt     = IDLE;
                        rsp_valid_nxt = NREQ'(1) << last_grant;
                        rsp_rdata_nxt = '0;
                        rsp_err_nxt   = 1'b1;
                        psel_nxt      = 1'b0;
                        penable_nxt   = 1'b0;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output and bookkeeping registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_grant <= GW'(NREQ - 1);
            wait_cnt   <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PPROT      <= '0;
            PSTRB      <= '0;
            PADDR      <= '0;
            PWDATA     <= '0;
        end else begin
            last_grant <= last_grant_nxt;
            wait_cnt   <= wait_cnt_nxt;
            req_ready  <= req_ready_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            rsp_err    <= rsp_err_nxt;
            PSEL       <= psel_nxt;
            PENABLE    <= penable_nxt;
            PWRITE     <= pwrite_nxt;
            PPROT      <= pprot_nxt;
            PSTRB      <= pstrb_nxt;
            PADDR      <= paddr_nxt;
            PWDATA     <= pwdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter (PDATA_SIZE=32, NREQ=4, TIMEOUT=16).
// Stimulus pushes expected grants/responses; a monitor pops and compares them.
module tb_apb_master_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;

    logic               PCLK;
    logic               PRESETn;
    logic [NR-1:0]      req_valid, req_write;
    logic [NR*DW-1:0]   req_addr, req_wdata;
    logic [NR*DW/8-1:0] req_strb;
    logic [NR*3-1:0]    req_prot;
    logic [NR-1:0]      req_ready, rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;
    logic               PSEL, PENABLE, PWRITE;
    logic [2:0]         PPROT;
    logic [DW/8-1:0]    PSTRB;
    logic [DW-1:0]      PADDR, PWDATA, PRDATA;
    logic               PREADY, PSLVERR;

    apb_master_arbiter #(.PDATA_SIZE(32), .NREQ(4), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PPROT(PPROT), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   gq[$];
    rsp_t rq[$];

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge PCLK);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        req_write[i]         = wr;
        req_addr[i*32 +: 32] = a;
        req_wdata[i*32 +: 32] = d;
        req_strb[i*4 +: 4]   = s;
        req_prot[i*3 +: 3]   = p;
        req_valid[i]         = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic [31:0] rd, input logic e);
        rsp_t r;
        r.idx = i; r.rdata = rd; r.err = e;
        gq.push_back(i);
        rq.push_back(r);
    endtask

    // Bounded wait for any req_ready pulse.
    task automatic wait_any(output logic [NR-1:0] seen);
        int n = 0;
        seen = '0;
        while (seen == '0 && n < 20) begin
            tick();
            n++;
            seen = req_ready;
        end
        chk("ready_seen", 64'(seen != '0), 64'(1));
    endtask

    // Wait for a grant and retire the granted requester's request.
    task automatic get_grant();
        logic [NR-1:0] seen;
        wait_any(seen);
        req_valid = req_valid & ~seen;
    endtask

    task automatic drain();
        int n = 0;
        while (rq.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        chk("rsp_drain", 64'(rq.size()), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psel"},    64'(PSEL),      64'(0));
        chk({tag, "_penable"}, 64'(PENABLE),   64'(0));
        chk({tag, "_paddr"},   64'(PADDR),     64'(0));
        chk({tag, "_pwdata"},  64'(PWDATA),    64'(0));
        chk({tag, "_pctl"},    64'({PWRITE, PPROT, PSTRB}), 64'(0));
        chk({tag, "_ready"},   64'(req_ready), 64'(0));
        chk({tag, "_rsp"},     64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    endtask

    // Monitor: every grant and response the DUT presents must match the scoreboard.
    int   mon_g;
    rsp_t mon_r;
    always @(negedge PCLK) begin
        if (PRESETn) begin
            if (req_ready != '0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 64'(req_ready), 64'(0));
                end else begin
                    mon_g = gq.pop_front();
                    chk("grant_onehot", 64'(req_ready), 64'(4'(1) << mon_g));
                end
            end
            if (rsp_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    mon_r = rq.pop_front();
                    chk("rsp_idx",   64'(rsp_valid), 64'(4'(1) << mon_r.idx));
                    chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_r.rdata));
                    chk("rsp_err",   64'(rsp_err),   64'(mon_r.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] seen;
        PRESETn = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_strb = '0;  req_prot = '0;
        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;

        // Reset state.
        #2;
        chk_all_zero("reset");
        repeat (2) tick();
        PRESETn = 1'b1;
        tick();

        // 1: single write from requester 0, PREADY high.
        push_exp(0, 32'h0, 1'b0);
        set_req(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b000);
        tick();
        chk("t1_ready",  64'(req_ready), 64'(4'b0001));
        chk("t1_setup",  64'({PSEL, PENABLE, PWRITE}), 64'(3'b101));
        chk("t1_paddr",  64'(PADDR),  64'(32'h10));
        chk("t1_pwdata", 64'(PWDATA), 64'(32'hA5A5_0001));
        chk("t1_pstrb",  64'(PSTRB),  64'(4'hF));
        req_valid[0] = 1'b0;
        tick();
        chk("t1_access", 64'({PSEL, PENABLE, req_ready}), 64'({2'b11, 4'b0000}));
        tick();
        chk("t1_rsp_lat", 64'(rsp_valid), 64'(4'b0001));
        chk("t1_idle",    64'({PSEL, PENABLE}), 64'(0));
        tick();
        chk("t1_hold_addr", 64'({PADDR, PWRITE}), 64'({32'h10, 1'b1}));

        // 2: read from requester 2 with three wait states.
        PREADY = 1'b0;
        push_exp(2, 32'hDEAD_BEEF, 1'b0);
        set_req(2, 1'b0, 32'h20, 32'h1234_5678, 4'hF, 3'b010);
        get_grant();
        chk("t2_pstrb", 64'(PSTRB),  64'(0));
        chk("t2_ctl",   64'({PWRITE, PPROT}), 64'({1'b0, 3'b010}));
        chk("t2_paddr", 64'(PADDR),  64'(32'h20));
        tick();
        chk("t2_penable", 64'(PENABLE), 64'(1));
        repeat (2) tick();
        chk("t2_wait", 64'({PSEL, PENABLE, rsp_valid}), 64'({2'b11, 4'b0000}));
        tick();
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        tick();
        chk("t2_rsp_lat", 64'(rsp_valid), 64'(4'b0100));
        PRDATA = 32'h0;
        tick();

        // 3: all requesters continuously valid after a reset.
        tick();
        #2 PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 32'h100 + 32'(i) * 4, 32'h5000 + 32'(i), 4'h3, 3'b001);
        end
        push_exp(0, 32'h0, 1'b0);
        push_exp(1, 32'h0, 1'b0);
        push_exp(2, 32'h0, 1'b0);
        push_exp(3, 32'h0, 1'b0);
        push_exp(0, 32'h0, 1'b0);
        for (int n = 0; n < 5; n++) begin
            wait_any(seen);
            chk("t3_onehot", 64'($onehot(seen)), 64'(1));
            if (n == 4) req_valid = '0;
            tick();
            chk("t3_pulse", 64'(req_ready), 64'(0));
        end
        drain();

        // 4: PSLVERR on a write from requester 1, then requester 2 wins.
        PSLVERR = 1'b1;
        PRDATA  = 32'h0BAD_F00D;
        set_req(0, 1'b1, 32'h40, 32'h4000, 4'h1, 3'b000);
        set_req(1, 1'b1, 32'h44, 32'h4444, 4'hF, 3'b000);
        set_req(2, 1'b0, 32'h48, 32'h0,    4'hF, 3'b000);
        push_exp(1, 32'h0, 1'b1);
        push_exp(2, 32'h0BAD_F00D, 1'b0);
        push_exp(0, 32'h0, 1'b0);
        get_grant();
        repeat (2) tick();
        chk("t4_err_rsp", 64'({rsp_valid, rsp_err}), 64'({4'b0010, 1'b1}));
        PSLVERR = 1'b0;
        get_grant();
        chk("t4_next_grant", 64'(PADDR), 64'(32'h48));
        get_grant();
        drain();

        // 5: timeout with PREADY held low, then a late PREADY.
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        push_exp(3, 32'h0, 1'b1);
        set_req(3, 1'b0, 32'h30, 32'h0, 4'hF, 3'b000);
        get_grant();
        repeat (16) tick();
        chk("t5_still_busy", 64'({PSEL, rsp_valid}), 64'({1'b1, 4'b0000}));
        tick();
        chk("t5_timeout", 64'({PSEL, PENABLE, rsp_valid, rsp_err}), 64'({2'b00, 4'b1000, 1'b1}));
        chk("t5_rdata", 64'(rsp_rdata), 64'(0));
        tick();
        PREADY = 1'b1;
        tick();
        PREADY = 1'b0;
        repeat (3) tick();
        chk("t5_no_second", 64'({PSEL, rsp_valid}), 64'(0));

        // 6: reset during ACCESS, then requester 0 beats requester 3.
        gq.push_back(1);
        set_req(1, 1'b0, 32'h60, 32'h0, 4'hF, 3'b111);
        get_grant();
        tick();
        chk("t6_in_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        #2 PRESETn = 1'b0;
        #1;
        chk_all_zero("t6_async");
        PREADY = 1'b1;
        repeat (3) tick();
        PRESETn = 1'b1;
        chk_all_zero("t6_released");
        tick();
        chk("t6_no_rsp", 64'(rsp_valid), 64'(0));
        PRDATA = 32'h0;
        set_req(0, 1'b1, 32'h70, 32'h7070, 4'hF, 3'b000);
        set_req(3, 1'b1, 32'h7C, 32'h7C7C, 4'hF, 3'b000);
        push_exp(0, 32'h0, 1'b0);
        push_exp(3, 32'h0, 1'b0);
        get_grant();
        chk("t6_first_addr", 64'(PADDR), 64'(32'h70));
        get_grant();
        drain();
        repeat (3) tick();
        chk("grant_queue_empty", 64'(gq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
